// File: rtl/alu_nibble_sequencer.sv
// Runs a wide ALU operation through one external 4-bit ALU slice,
// one nibble per clock, LSB first, chaining the active-low carry.
module alu_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic [3:0]             op_s,
  input  logic                   op_m,
  input  logic                   op_cin_re,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout_re,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [3:0]             alu_s,
  output logic                   alu_m,
  output logic                   alu_cin_re,
  input  logic [3:0]             alu_y,
  input  logic                   alu_cout_re
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [3:0]    s_q;
  logic          m_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      result  <= '0;
      cout_re <= 1'b1;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_q    <= op_a;
            b_q    <= op_b;
            s_q    <= op_s;
            m_q    <= op_m;
            carry  <= op_cin_re;
            idx    <= '0;
            result <= '0;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          result[{idx, 2'b00} +: 4] <= alu_y;
          carry <= alu_cout_re;
          if (idx == LAST) begin
            // logic-mode carry from the slice is meaningless; report none
            cout_re <= m_q ? 1'b1 : alu_cout_re;
            idx     <= '0;
            state   <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Park the slice in logic mode with no carry whenever idle
  always_comb begin
    alu_a      = 4'h0;
    alu_b      = 4'h0;
    alu_s      = 4'h0;
    alu_m      = 1'b1;
    alu_cin_re = 1'b1;
    if (busy) begin
      alu_a      = a_q[{idx, 2'b00} +: 4];
      alu_b      = b_q[{idx, 2'b00} +: 4];
      alu_s      = s_q;
      alu_m      = m_q;
      alu_cin_re = carry;
    end
  end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: behavioural 4-bit ALU slice, vector
// table, multi-cycle corner sequences and a randomized wide reference.
module tb_alu_nibble_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [3:0]  op_s;
  logic        op_m;
  logic        op_cin_re;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout_re;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [3:0]  alu_s;
  logic        alu_m;
  logic        alu_cin_re;
  logic [3:0]  alu_y;
  logic        alu_cout_re;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  s;
    logic        m;
    logic        cin;
    logic [15:0] res;
    logic        cout;
  } vec_t;

  vec_t        tbl[8];
  logic [3:0]  cin_seq;
  logic [16:0] exp_w;

  alu_nibble_sequencer #(.NIBBLES(4)) dut (
    .clock(clock), .reset(reset), .start(start),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m),
    .op_cin_re(op_cin_re), .busy(busy), .done(done),
    .result(result), .cout_re(cout_re),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
    .alu_cin_re(alu_cin_re), .alu_y(alu_y),
    .alu_cout_re(alu_cout_re)
  );

  always #5 clock = ~clock;

  // 74181-style slice, active-high data, active-low carries
  function automatic logic [4:0] alu4(
    input logic [3:0] a, input logic [3:0] b,
    input logic [3:0] s, input logic m, input logic cin_re);
    logic [3:0] x, y;
    logic [4:0] sum;
    x = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    y = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    sum = {1'b0, x} + {1'b0, y} + {4'b0, ~cin_re};
    // in logic mode the slice still emits a garbage carry
    return m ? {~sum[4], ~(x ^ y)} : {~sum[4], sum[3:0]};
  endfunction

  assign {alu_cout_re, alu_y} = alu4(alu_a, alu_b, alu_s, alu_m, alu_cin_re);

  // Wide reference: one 16-bit evaluation of the same function rules
  function automatic logic [16:0] model(
    input logic [15:0] a, input logic [15:0] b,
    input logic [3:0] s, input logic m, input logic cin_re);
    logic [15:0] x, y;
    logic [16:0] sum;
    x = a | (b & {16{s[0]}}) | (~b & {16{s[1]}});
    y = (a & ~b & {16{s[2]}}) | (a & b & {16{s[3]}});
    sum = {1'b0, x} + {1'b0, y} + {16'b0, ~cin_re};
    return m ? {1'b1, ~(x ^ y)} : {~sum[16], sum[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] s, input logic m,
                          input logic cin);
    @(negedge clock);
    op_a = a; op_b = b; op_s = s; op_m = m; op_cin_re = cin;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Waits for done from cycle n=first after the start edge
  task automatic wait_done(input int first, output int lat,
                           output int bcnt);
    lat  = first;
    bcnt = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) begin
        if (bcnt < 4) cin_seq[bcnt] = alu_cin_re;
        bcnt++;
      end
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat, bcnt;
    start_op(v.a, v.b, v.s, v.m, v.cin);
    wait_done(1, lat, bcnt);
    chk({name, " latency"}, lat, 5);
    chk({name, " busy_cycles"}, bcnt, 4);
    chk({name, " result"}, result, v.res);
    chk({name, " cout_re"}, cout_re, v.cout);
    @(negedge clock);
    chk({name, " done_pulse"}, {busy, done}, 2'b00);
  endtask

  initial begin
    int lat, bcnt;
    bit saw_done;
    vec_t v;

    tbl[0] = '{16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0100, 1'b1};
    tbl[1] = '{16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0};
    tbl[2] = '{16'h0000, 16'h0000, 4'b1001, 1'b0, 1'b0, 16'h0001, 1'b1};
    tbl[3] = '{16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 16'h0FF0, 1'b1};
    tbl[4] = '{16'h0005, 16'h0003, 4'b0110, 1'b0, 1'b0, 16'h0002, 1'b0};
    tbl[5] = '{16'h1234, 16'h5678, 4'b0011, 1'b0, 1'b1, 16'hFFFF, 1'b1};
    tbl[6] = '{16'h8001, 16'h0000, 4'b1100, 1'b0, 1'b1, 16'h0002, 1'b0};
    tbl[7] = '{16'h1234, 16'h0F0F, 4'b1011, 1'b1, 1'b1, 16'h0204, 1'b1};

    reset = 1'b1; start = 1'b0;
    op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0; op_cin_re = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst busy_done", {busy, done}, 2'b00);
    chk("rst result", result, 16'h0000);
    chk("rst cout_re", cout_re, 1'b1);
    chk("rst alu_park", {alu_a, alu_b, alu_s, alu_m, alu_cin_re},
        {12'h000, 2'b11});
    reset = 1'b0;
    @(negedge clock);
    chk("idle busy_done", {busy, done}, 2'b00);

    for (int i = 0; i < 8; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i]);
      if (i == 2) chk("vec2 alu_cin_seq", cin_seq, 4'b1110);
    end

    // start during RUN ignored; start during DONE accepted
    start_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1);
    @(negedge clock);
    op_a = 16'hAAAA; op_b = 16'h5555; op_s = 4'b0110; op_m = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(3, lat, bcnt);
    chk("ign latency", lat, 5);
    chk("ign result", result, 16'h0100);
    chk("ign cout_re", cout_re, 1'b1);
    op_a = 16'h0003; op_b = 16'h0004; op_s = 4'b1001; op_m = 1'b0;
    op_cin_re = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("b2b cleared", {busy, result}, {1'b1, 16'h0000});
    wait_done(1, lat, bcnt);
    chk("b2b latency", lat, 5);
    chk("b2b result", result, 16'h0007);
    @(negedge clock);

    // reset on the 3rd RUN cycle
    start_op(16'h1234, 16'h1111, 4'b1001, 1'b0, 1'b1);
    repeat (2) @(negedge clock);
    chk("pre_rst partial", result, 16'h0045);
    reset = 1'b1;
    #1;
    chk("mid_rst state", {busy, done, cout_re}, 3'b001);
    chk("mid_rst result", result, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    chk("post_rst idle", saw_done, 1'b0);
    run_vec("post_rst op", tbl[0]);

    for (int i = 0; i < 1000; i++) begin
      v.a   = 16'($urandom);
      v.b   = 16'($urandom);
      v.s   = 4'($urandom);
      v.m   = 1'($urandom);
      v.cin = 1'($urandom);
      exp_w  = model(v.a, v.b, v.s, v.m, v.cin);
      v.res  = exp_w[15:0];
      v.cout = exp_w[16];
      run_vec($sformatf("rnd%0d", i), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
